// File: rtl/boot_copier_if.sv
// Wishbone master bundle for the boot copier: ROM read port and RAM write port.
interface boot_copier_if;
  logic [31:0] wbm_rom_adr_o;
  logic        wbm_rom_stb_o;
  logic [31:0] wbm_rom_dat_i;
  logic        wbm_rom_ack_i;
  logic [31:0] wbm_ram_adr_o;
  logic [31:0] wbm_ram_dat_o;
  logic [3:0]  wbm_ram_sel_o;
  logic        wbm_ram_we_o;
  logic        wbm_ram_stb_o;
  logic        wbm_ram_ack_i;

  modport master (
    output wbm_rom_adr_o, wbm_rom_stb_o,
    input  wbm_rom_dat_i, wbm_rom_ack_i,
    output wbm_ram_adr_o, wbm_ram_dat_o, wbm_ram_sel_o, wbm_ram_we_o, wbm_ram_stb_o,
    input  wbm_ram_ack_i
  );

  modport slave (
    input  wbm_rom_adr_o, wbm_rom_stb_o,
    output wbm_rom_dat_i, wbm_rom_ack_i,
    input  wbm_ram_adr_o, wbm_ram_dat_o, wbm_ram_sel_o, wbm_ram_we_o, wbm_ram_stb_o,
    output wbm_ram_ack_i
  );
endinterface

// File: rtl/boot_copier.sv
// Copies DEPTH bytes of boot ROM into RAM word by word, then releases the CPU reset.
// Optional running word sum on checksum_o when BOOT_COPIER_CHECKSUM_EN is defined.
//
// state  | meaning
// S_RD   | ROM read of word idx outstanding
// S_WR   | RAM write of latched word to idx outstanding
// S_DONE | image complete, CPU running
module boot_copier #(
  parameter int unsigned DEPTH    = 256,
  parameter logic [31:0] ROM_BASE = 32'h0000_0000,
  parameter logic [31:0] RAM_BASE = 32'h0000_0000
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  boot_copier_if.master bus,
  output logic          cpu_rst_o,
  output logic          done_o,
  output logic [31:0]   checksum_o
);

  localparam int unsigned WORDS = DEPTH / 4;
  localparam int unsigned IDX_W = (WORDS > 0) ? $clog2(WORDS + 1) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'((WORDS > 0) ? WORDS - 1 : 0);

  typedef enum logic [1:0] {
    S_RD   = 2'd0,
    S_WR   = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam state_t RST_STATE = (WORDS == 0) ? S_DONE : S_RD;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [31:0]      r_data, w_data_nxt;
  logic             r_rom_stb, w_rom_stb_nxt;
  logic             r_ram_stb, w_ram_stb_nxt;
  logic             r_done, w_done_nxt;
  logic             r_cpu_rst, w_cpu_rst_nxt;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state   <= RST_STATE;
      r_idx     <= '0;
      r_data    <= '0;
      r_rom_stb <= 1'b0;
      r_ram_stb <= 1'b0;
      r_done    <= (WORDS == 0);
      r_cpu_rst <= (WORDS != 0);
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_data    <= w_data_nxt;
      r_rom_stb <= w_rom_stb_nxt;
      r_ram_stb <= w_ram_stb_nxt;
      r_done    <= w_done_nxt;
      r_cpu_rst <= w_cpu_rst_nxt;
    end
  end

  // Acks only count while our own stb is up, so stray acks are ignored.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_data_nxt    = r_data;
    w_rom_stb_nxt = 1'b0;
    w_ram_stb_nxt = 1'b0;
    w_done_nxt    = r_done;
    w_cpu_rst_nxt = r_cpu_rst;
    case (r_state)
      S_RD: begin
        w_rom_stb_nxt = 1'b1;
        if (r_rom_stb && bus.wbm_rom_ack_i) begin
          w_data_nxt    = bus.wbm_rom_dat_i;
          w_rom_stb_nxt = 1'b0;
          w_ram_stb_nxt = 1'b1;
          w_state_nxt   = S_WR;
        end
      end
      S_WR: begin
        w_ram_stb_nxt = 1'b1;
        if (r_ram_stb && bus.wbm_ram_ack_i) begin
          w_ram_stb_nxt = 1'b0;
          if (r_idx == LAST) begin
            w_state_nxt   = S_DONE;
            w_done_nxt    = 1'b1;
            w_cpu_rst_nxt = 1'b0;
          end else begin
            w_idx_nxt     = r_idx + IDX_W'(1);
            w_rom_stb_nxt = 1'b1;
            w_state_nxt   = S_RD;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.wbm_rom_adr_o = ROM_BASE + (32'(r_idx) << 2);
  assign bus.wbm_rom_stb_o = r_rom_stb;
  assign bus.wbm_ram_adr_o = RAM_BASE + (32'(r_idx) << 2);
  assign bus.wbm_ram_dat_o = r_data;
  assign bus.wbm_ram_sel_o = 4'hF;
  assign bus.wbm_ram_we_o  = 1'b1;
  assign bus.wbm_ram_stb_o = r_ram_stb;
  assign cpu_rst_o         = r_cpu_rst;
  assign done_o            = r_done;

`ifdef BOOT_COPIER_CHECKSUM_EN
  logic        w_latch;
  logic [31:0] r_sum;

  assign w_latch = (r_state == S_RD) && r_rom_stb && bus.wbm_rom_ack_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_sum <= '0;
    end else if (w_latch) begin
      r_sum <= r_sum + bus.wbm_rom_dat_i;
    end
  end

  assign checksum_o = r_sum;
`else
  assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_boot_copier.sv
// Directed bench for boot_copier: zero-wait and 3-wait copies, mid-copy reset,
// stray acks, DEPTH=0 instance and checksum (BOOT_COPIER_CHECKSUM_EN aware).
module tb_boot_copier;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned WORDS = DEPTH / 4;
  localparam logic [31:0] ROM_BASE = 32'h0000_1000;
  localparam logic [31:0] RAM_BASE = 32'h8000_0040;
`ifdef BOOT_COPIER_CHECKSUM_EN
  localparam logic [31:0] SUM1 = 32'hAAAA_AAAA;
  localparam logic [31:0] SUM_W0 = 32'h0000_0001;
  localparam logic [31:0] SUM2 = 32'h0000_0005;
`else
  localparam logic [31:0] SUM1 = 32'h0;
  localparam logic [31:0] SUM_W0 = 32'h0;
  localparam logic [31:0] SUM2 = 32'h0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  boot_copier_if bus ();
  boot_copier_if bus0 ();
  logic        cpu_rst, done, cpu_rst0, done0;
  logic [31:0] csum, csum0;

  boot_copier #(.DEPTH(DEPTH), .ROM_BASE(ROM_BASE), .RAM_BASE(RAM_BASE)) u_dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(bus),
    .cpu_rst_o(cpu_rst), .done_o(done), .checksum_o(csum)
  );

  boot_copier #(.DEPTH(0), .ROM_BASE(ROM_BASE), .RAM_BASE(RAM_BASE)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(bus0),
    .cpu_rst_o(cpu_rst0), .done_o(done0), .checksum_o(csum0)
  );

  int total = 0, passed = 0, failed = 0;
  logic [31:0] rom [WORDS];
  int lat, rom_cnt, ram_cnt, cyc, first_stb, done_cyc;
  logic [31:0] wr_adr[$], wr_dat[$];
  logic [3:0]  wr_sel[$];
  bit spur_ram, spur_rom, chk_stable, stb0_seen, both_hi, rst_mismatch;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: registered ROM/RAM slave models with programmable ack latency.
  task automatic tick();
    logic        n_rack, n_wack, p_rstb, p_wstb, p_rack, p_wack;
    logic [31:0] n_rdat, off, p_radr, p_wadr, p_wdat;
    p_rstb = bus.wbm_rom_stb_o;  p_rack = bus.wbm_rom_ack_i;  p_radr = bus.wbm_rom_adr_o;
    p_wstb = bus.wbm_ram_stb_o;  p_wack = bus.wbm_ram_ack_i;  p_wadr = bus.wbm_ram_adr_o;
    p_wdat = bus.wbm_ram_dat_o;
    if (p_wstb && p_wack) begin
      wr_adr.push_back(p_wadr);
      wr_dat.push_back(p_wdat);
      wr_sel.push_back(bus.wbm_ram_sel_o);
    end
    if (p_rstb && p_wstb) both_hi = 1'b1;
    if (bus0.wbm_rom_stb_o || bus0.wbm_ram_stb_o) stb0_seen = 1'b1;
    n_rack = 1'b0;
    n_wack = 1'b0;
    n_rdat = bus.wbm_rom_dat_i;
    if (p_rstb && !p_rack) begin
      if (rom_cnt >= lat - 1) begin
        n_rack  = 1'b1;
        rom_cnt = 0;
        off     = p_radr - ROM_BASE;
        n_rdat  = rom[off[3:2]];
      end else rom_cnt++;
    end
    if (p_wstb && !p_wack) begin
      if (ram_cnt >= lat - 1) begin
        n_wack  = 1'b1;
        ram_cnt = 0;
      end else ram_cnt++;
    end
    if (spur_ram) n_wack = 1'b1;
    if (spur_rom) begin
      n_rack = 1'b1;
      n_rdat = 32'hDEAD_BEEF;
    end
    spur_ram = 1'b0;
    spur_rom = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    bus.wbm_rom_ack_i = n_rack;
    bus.wbm_rom_dat_i = n_rdat;
    bus.wbm_ram_ack_i = n_wack;
    if (first_stb < 0 && bus.wbm_rom_stb_o === 1'b1) first_stb = cyc;
    if (done_cyc < 0 && done === 1'b1) done_cyc = cyc;
    if (cpu_rst !== ~done) rst_mismatch = 1'b1;
    if (chk_stable) begin
      if (p_rstb && !p_rack) begin
        chk("rom_stb_hold", 32'(bus.wbm_rom_stb_o), 32'd1);
        chk("rom_adr_hold", bus.wbm_rom_adr_o, p_radr);
      end
      if (p_wstb && !p_wack) begin
        chk("ram_stb_hold", 32'(bus.wbm_ram_stb_o), 32'd1);
        chk("ram_adr_hold", bus.wbm_ram_adr_o, p_wadr);
        chk("ram_dat_hold", bus.wbm_ram_dat_o, p_wdat);
      end
    end
  endtask

  task automatic slave_clear();
    bus.wbm_rom_ack_i = 1'b0;
    bus.wbm_ram_ack_i = 1'b0;
    rom_cnt = 0;
    ram_cnt = 0;
    spur_ram = 1'b0;
    spur_rom = 1'b0;
  endtask

  task automatic release_rst();
    rst_n = 1'b1;
    cyc = 0;
    first_stb = -1;
    done_cyc = -1;
    wr_adr.delete();
    wr_dat.delete();
    wr_sel.delete();
  endtask

  task automatic run_to_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, 32'(wr_adr.size()), 32'(WORDS));
    for (int i = 0; i < wr_adr.size() && i < WORDS; i++) begin
      chk({tag, "_wr_adr"}, wr_adr[i], RAM_BASE + 32'(4 * i));
      chk({tag, "_wr_dat"}, wr_dat[i], rom[i]);
      chk({tag, "_wr_sel"}, 32'(wr_sel[i]), 32'hF);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    bus.wbm_rom_dat_i = '0;
    bus0.wbm_rom_dat_i = '0;
    bus0.wbm_rom_ack_i = 1'b0;
    bus0.wbm_ram_ack_i = 1'b0;
    slave_clear();
    lat = 1;
    cyc = 0;
    first_stb = -1;
    done_cyc = -1;
    chk_stable = 1'b0;
    stb0_seen = 1'b0;
    both_hi = 1'b0;
    rst_mismatch = 1'b0;
    rom[0] = 32'h1111_1111;
    rom[1] = 32'h2222_2222;
    rom[2] = 32'h3333_3333;
    rom[3] = 32'h4444_4444;
    repeat (3) tick();

    chk("rst_rom_stb", 32'(bus.wbm_rom_stb_o), 32'd0);
    chk("rst_ram_stb", 32'(bus.wbm_ram_stb_o), 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_csum", csum, 32'd0);
    chk("rst_ram_dat", bus.wbm_ram_dat_o, 32'd0);
    chk("rst_rom_adr", bus.wbm_rom_adr_o, ROM_BASE);
    chk("rst_ram_adr", bus.wbm_ram_adr_o, RAM_BASE);
    chk("rst_we", 32'(bus.wbm_ram_we_o), 32'd1);
    chk("d0_rst_done", 32'(done0), 32'd1);
    chk("d0_rst_cpu_rst", 32'(cpu_rst0), 32'd0);

    // Zero-wait copy.
    release_rst();
    run_to_done("t1");
    chk("t1_first_stb", 32'(first_stb), 32'd1);
    chk("t1_done_delay", 32'(done_cyc - first_stb), 32'd16);
    repeat (4) tick();
    check_writes("t1");
    chk("t1_idle_rom_stb", 32'(bus.wbm_rom_stb_o), 32'd0);
    chk("t1_idle_ram_stb", 32'(bus.wbm_ram_stb_o), 32'd0);
    chk("t1_csum", csum, SUM1);
    chk("d0_done", 32'(done0), 32'd1);
    chk("d0_cpu_rst", 32'(cpu_rst0), 32'd0);

    // Three-cycle ack latency with hold checks on every wait cycle.
    rst_n = 1'b0;
    slave_clear();
    repeat (2) tick();
    lat = 3;
    chk_stable = 1'b1;
    release_rst();
    run_to_done("t2");
    chk_stable = 1'b0;
    chk("t2_done_delay", 32'(done_cyc - first_stb), 32'd32);
    repeat (8) tick();
    check_writes("t2");

    // Reset after two RAM acks, then a full restart.
    rst_n = 1'b0;
    slave_clear();
    tick();
    lat = 1;
    release_rst();
    n = 0;
    while (wr_adr.size() < 2 && n < 100) begin
      tick();
      n++;
    end
    chk("t3_two_writes", 32'(wr_adr.size()), 32'd2);
    chk("t3_pre_rom_stb", 32'(bus.wbm_rom_stb_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t3_rst_rom_stb", 32'(bus.wbm_rom_stb_o), 32'd0);
    chk("t3_rst_ram_stb", 32'(bus.wbm_ram_stb_o), 32'd0);
    chk("t3_rst_rom_adr", bus.wbm_rom_adr_o, ROM_BASE);
    chk("t3_rst_ram_dat", bus.wbm_ram_dat_o, 32'd0);
    chk("t3_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t3_rst_done", 32'(done), 32'd0);
    chk("t3_rst_csum", csum, 32'd0);
    slave_clear();
    repeat (2) tick();
    chk("t3_hold_rom_stb", 32'(bus.wbm_rom_stb_o), 32'd0);
    release_rst();
    tick();
    chk("t3_restart_stb", 32'(bus.wbm_rom_stb_o), 32'd1);
    chk("t3_restart_adr", bus.wbm_rom_adr_o, ROM_BASE);
    run_to_done("t3");
    check_writes("t3");

    // Stray RAM ack during RD and stray ROM ack during WR.
    rst_n = 1'b0;
    slave_clear();
    rom[0] = 32'h0000_0001;
    rom[1] = 32'h0000_0002;
    rom[2] = 32'h0000_0003;
    rom[3] = 32'hFFFF_FFFF;
    tick();
    lat = 3;
    release_rst();
    tick();
    spur_ram = 1'b1;
    tick();
    tick();
    chk("t4_rd_rom_stb", 32'(bus.wbm_rom_stb_o), 32'd1);
    chk("t4_rd_ram_stb", 32'(bus.wbm_ram_stb_o), 32'd0);
    chk("t4_rd_rom_adr", bus.wbm_rom_adr_o, ROM_BASE);
    chk("t4_rd_ram_adr", bus.wbm_ram_adr_o, RAM_BASE);
    chk("t4_rd_ram_dat", bus.wbm_ram_dat_o, 32'd0);
    n = 0;
    while (bus.wbm_ram_stb_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("t4_wr_entered", 32'(bus.wbm_ram_stb_o), 32'd1);
    spur_rom = 1'b1;
    tick();
    tick();
    chk("t4_wr_ram_stb", 32'(bus.wbm_ram_stb_o), 32'd1);
    chk("t4_wr_rom_stb", 32'(bus.wbm_rom_stb_o), 32'd0);
    chk("t4_wr_ram_adr", bus.wbm_ram_adr_o, RAM_BASE);
    chk("t4_wr_ram_dat", bus.wbm_ram_dat_o, 32'd1);
    chk("t4_wr_csum", csum, SUM_W0);
    run_to_done("t4");
    repeat (4) tick();
    check_writes("t4");
    chk("t4_csum", csum, SUM2);

    chk("never_both_stb", 32'(both_hi), 32'd0);
    chk("d0_no_stb", 32'(stb0_seen), 32'd0);
    chk("cpu_rst_vs_done", 32'(rst_mismatch), 32'd0);
    chk("d0_csum", csum0, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/boot_copier.md
# boot_copier

Boot-time sequencer that copies the boot ROM image into main RAM, then releases the CPU from reset. It sits between the boot ROM (Wishbone slave, registered single-cycle ack) and the RAM's Wishbone slave port. It owns the CPU reset, so the core never fetches from RAM before the image is complete.

## Interface
Parameters:
- DEPTH, 256, bytes to copy; must be a multiple of 4 (low 2 bits ignored, word count = DEPTH/4)
- ROM_BASE, 32'h0000_0000, byte address of first ROM word
- RAM_BASE, 32'h0000_0000, byte address of first RAM word

Ports:
- wb_clk_i  in  1  clock
- wb_rst_n_i  in  1  reset, asynchronous assert, active-low
- wbm_rom_adr_o  out  32  ROM read address (word-aligned)
- wbm_rom_stb_o  out  1  ROM request (also serves as cyc)
- wbm_rom_dat_i  in  32  ROM read data, valid with ack
- wbm_rom_ack_i  in  1  ROM acknowledge
- wbm_ram_adr_o  out  32  RAM write address (word-aligned)
- wbm_ram_dat_o  out  32  RAM write data
- wbm_ram_sel_o  out  4  byte selects, constant 4'hF
- wbm_ram_we_o  out  1  write enable, constant 1
- wbm_ram_stb_o  out  1  RAM request (also serves as cyc)
- wbm_ram_ack_i  in  1  RAM acknowledge
- cpu_rst_o  out  1  active-high CPU reset
- done_o  out  1  copy complete, sticky until reset
- checksum_o  out  32  running word sum (see Configuration)

## Operation
- FSM states: RD, WR, DONE. Word counter idx, width $clog2(DEPTH/4+1).
- Reset: state RD (DONE if DEPTH/4 == 0), idx=0, both stb=0, data register=0, cpu_rst_o=1, done_o=0, checksum_o=0.
- RD: wbm_rom_stb_o=1, wbm_rom_adr_o = ROM_BASE + 4*idx. On a sampled wbm_rom_ack_i, latch wbm_rom_dat_i into the data register, drop rom stb, go to WR.
- WR: wbm_ram_stb_o=1, wbm_ram_adr_o = RAM_BASE + 4*idx, wbm_ram_dat_o = latched word. On a sampled wbm_ram_ack_i, drop ram stb. If idx == DEPTH/4-1, go to DONE; else idx+1 and go to RD.
- DONE: both stb=0, done_o=1, cpu_rst_o=0. The block stays here until reset.
- Addresses are 32-bit modular. Wrap past 2^32 is not checked.
- Acks are ignored while the matching stb is low: no state change, no data latch. A ROM ack in WR and a RAM ack in RD are both ignored.
- Both stb outputs are never high in the same cycle.
- Reset asserted mid-copy: all outputs return to reset values immediately. After release, the copy restarts from idx=0.

## Timing
- All outputs are registered. Stb is held high, with address and data stable, until ack is sampled. Stb drops on the edge that samples ack, so the slave sees stb low the following cycle.
- Zero-wait slaves (ack one cycle after stb, as the boot ROM does) give 4 cycles per word: 2 in RD, 2 in WR.
- First rom stb is high in the first cycle after reset release.
- done_o rises and cpu_rst_o falls together, on the edge that samples the final RAM ack. With zero-wait slaves this is 4*DEPTH/4 cycles after release.
- DEPTH/4 == 0: done_o=1 and cpu_rst_o=0 from reset onward.

## Configuration
- BOOT_COPIER_CHECKSUM_EN defined: checksum_o accumulates each latched ROM word, as a 32-bit sum modulo 2^32. It updates on the cycle the word is latched and is final when done_o rises.
- Not defined: no accumulator is built and checksum_o is constant 0.

## Test plan
- DEPTH=16, ROM = 0x11111111, 0x22222222, 0x33333333, 0x44444444, zero-wait slaves -> 4 RAM writes to RAM_BASE+0x0/0x4/0x8/0xC with matching data, sel=4'hF. done_o=1 and cpu_rst_o=0 at cycle 16 after release.
- Slaves ack 3 cycles after stb -> stb, adr and dat stable through every wait cycle. Exactly 4 writes occur, and done_o rises at cycle 32.
- Reset pulsed after 2 RAM acks -> outputs return to reset values during reset. After release, the first rom adr is ROM_BASE and all 4 words are rewritten.
- Spurious wbm_ram_ack_i pulse during RD, and wbm_rom_ack_i during WR -> no state, address or data change.
- DEPTH=0 -> done_o=1 and cpu_rst_o=0 immediately after release, with no stb ever asserted.
- BOOT_COPIER_CHECKSUM_EN with ROM words 1,2,3,0xFFFFFFFF -> checksum_o=5 at done. Without the macro, checksum_o=0 throughout.
